// File: rtl/keypad_digit_entry_pkg.sv
// Shared types and constants for the keypad digit entry front-end.
package keypad_digit_entry_pkg;

  localparam int KEY_W = 10;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_SECONDS_TENS = 4'd5;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} db_state_t;

  typedef struct packed {
    logic valid;
    bcd_t code;
  } key_code_t;

  // Exactly one line high gives a valid code; none or several read as released.
  function automatic key_code_t encode_key(input logic [KEY_W-1:0] keys);
    key_code_t r;
    int        n;
    r = '0;
    n = 0;
    for (int i = 0; i < KEY_W; i++) begin
      if (keys[i]) begin
        n++;
        r.code = bcd_t'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_digit_entry_key_debouncer.sv
// Synchronizes the raw keypad, decodes it and emits one press strobe per debounced press.
module keypad_digit_entry_key_debouncer
  import keypad_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] keypad,
  output logic             press,
  output logic [3:0]       code
);

  localparam logic [7:0] DB_N = 8'(DEBOUNCE_CYCLES);

  logic [KEY_W-1:0] sync1, sync2;
  db_state_t        state;
  logic [7:0]       cnt;
  bcd_t             cand;
  key_code_t        enc;
  logic             stable;

  assign enc    = encode_key(sync2);
  assign stable = enc.valid && (enc.code == cand);
  assign press  = (state == PRESS_DB) && stable && (cnt == DB_N);
  assign code   = cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
      case (state)
        IDLE: if (enc.valid) begin
          state <= PRESS_DB;
          cnt   <= '0;
          cand  <= enc.code;
        end
        PRESS_DB: begin
          if (!stable)             state <= IDLE;
          else if (cnt == DB_N)    state <= HELD;
          else                     cnt   <= cnt + 8'd1;
        end
        // A code change while held is the same press; only a release ends it.
        HELD: if (!enc.valid) begin
          state <= RELEASE_DB;
          cnt   <= '0;
        end
        RELEASE_DB: begin
          if (enc.valid)           state <= HELD;
          else if (cnt == DB_N)    state <= IDLE;
          else                     cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad to countdown digit loader: debounce, then validate each press against m:ss limits.
module keypad_digit_entry
  import keypad_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [KEY_W-1:0] keypad,
  input  logic             entry_en,
  input  logic             clear_entry,
  output logic [3:0]       digit,
  output logic             load,
  output logic             reject,
  output logic [1:0]       digits_entered
);

  localparam logic [1:0] MAX_D = 2'(MAX_DIGITS);

  logic press;
  bcd_t key_code;
  bcd_t shadow;

  keypad_digit_entry_key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk    (clk),
    .rst    (clear),
    .keypad (keypad),
    .press  (press),
    .code   (key_code)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      digit          <= '0;
      load           <= 1'b0;
      reject         <= 1'b0;
      digits_entered <= '0;
      shadow         <= '0;
    end else begin
      load   <= 1'b0;
      reject <= 1'b0;
      if (clear_entry) begin
        digits_entered <= '0;
        shadow         <= '0;
      end else if (press && entry_en) begin
        if (digits_entered == 2'd0 && key_code == 4'd0) begin
          // leading zero carries no information
        end else if (digits_entered == MAX_D) begin
          reject <= 1'b1;
        end else if (digits_entered != 2'd0 && shadow > MAX_SECONDS_TENS) begin
          // current units would shift into tens-of-seconds
          reject <= 1'b1;
        end else begin
          load           <= 1'b1;
          digit          <= key_code;
          shadow         <= key_code;
          digits_entered <= digits_entered + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with DEBOUNCE_CYCLES=4, MAX_DIGITS=3.
module tb_keypad_digit_entry;

  logic       clk = 1'b0;
  logic       clear;
  logic [9:0] keypad;
  logic       entry_en;
  logic       clear_entry;
  logic [3:0] digit;
  logic       load;
  logic       reject;
  logic [1:0] digits_entered;

  int errors = 0;
  int checks = 0;
  int both   = 0;

  keypad_digit_entry #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(3)) dut (
    .clk            (clk),
    .clear          (clear),
    .keypad         (keypad),
    .entry_en       (entry_en),
    .clear_entry    (clear_entry),
    .digit          (digit),
    .load           (load),
    .reject         (reject),
    .digits_entered (digits_entered)
  );

  always #5 clk = ~clk;

  // Holds pattern for hold cycles, releases, waits out release debounce; counts pulses.
  task automatic run_key(input logic [9:0] pat, input int hold,
                         output int nl, output int nr, output int first);
    nl = 0; nr = 0; first = -1;
    keypad = pat;
    for (int i = 0; i < hold + 12; i++) begin
      if (i == hold) keypad = '0;
      @(negedge clk);
      if (load) begin nl++; if (first < 0) first = i; end
      if (reject) nr++;
      if (load && reject) both++;
    end
  endtask

  task automatic pulse_clear_entry();
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({digit, load, reject, digits_entered} !== 8'h00) begin errors++;
      $display("FAIL reset_outputs: got %h expected 00", {digit, load, reject, digits_entered}); end
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++; if ({load, reject, digits_entered} !== 4'h0) begin errors++;
      $display("FAIL reset_idle: got %h expected 0", {load, reject, digits_entered}); end
  endtask

  task automatic test_single_key();
    int nl, nr, first;
    run_key(10'h010, 20, nl, nr, first);
    checks++; if (nl !== 1) begin errors++; $display("FAIL single_loads: got %0d expected 1", nl); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL single_rejects: got %0d expected 0", nr); end
    checks++; if (first !== 7) begin errors++; $display("FAIL single_latency: got %0d expected 7", first); end
    checks++; if (digit !== 4'd4) begin errors++; $display("FAIL single_digit: got %0d expected 4", digit); end
    checks++; if (digits_entered !== 2'd1) begin errors++;
      $display("FAIL single_count: got %0d expected 1", digits_entered); end
  endtask

  task automatic test_sequence();
    int nl, nr, first, tl;
    logic [3:0] got [3];
    pulse_clear_entry();
    tl = 0;
    run_key(10'h002, 10, nl, nr, first); tl += nl; got[0] = digit;
    run_key(10'h008, 10, nl, nr, first); tl += nl; got[1] = digit;
    run_key(10'h001, 10, nl, nr, first); tl += nl; got[2] = digit;
    checks++; if (tl !== 3) begin errors++; $display("FAIL seq_loads: got %0d expected 3", tl); end
    checks++; if ({got[0], got[1], got[2]} !== 12'h130) begin errors++;
      $display("FAIL seq_digits: got %h expected 130", {got[0], got[1], got[2]}); end
    checks++; if (digits_entered !== 2'd3) begin errors++;
      $display("FAIL seq_count: got %0d expected 3", digits_entered); end
    run_key(10'h080, 10, nl, nr, first);
    checks++; if (nl !== 0 || nr !== 1) begin errors++;
      $display("FAIL seq_fourth: got loads=%0d rejects=%0d expected 0/1", nl, nr); end
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL seq_hold_digit: got %0d expected 0", digit); end
  endtask

  task automatic test_tens_limit();
    int nl, nr, first;
    pulse_clear_entry();
    run_key(10'h100, 10, nl, nr, first);
    checks++; if (nl !== 1 || digit !== 4'd8) begin errors++;
      $display("FAIL tens_first: got loads=%0d digit=%0d expected 1/8", nl, digit); end
    run_key(10'h004, 10, nl, nr, first);
    checks++; if (nl !== 0 || nr !== 1) begin errors++;
      $display("FAIL tens_reject: got loads=%0d rejects=%0d expected 0/1", nl, nr); end
    checks++; if (digits_entered !== 2'd1 || digit !== 4'd8) begin errors++;
      $display("FAIL tens_state: got count=%0d digit=%0d expected 1/8", digits_entered, digit); end
  endtask

  task automatic test_leading_zero();
    int nl, nr, first;
    pulse_clear_entry();
    run_key(10'h001, 10, nl, nr, first);
    checks++; if (nl !== 0 || nr !== 0 || digits_entered !== 2'd0) begin errors++;
      $display("FAIL lead_zero: got loads=%0d rejects=%0d count=%0d expected 0/0/0", nl, nr, digits_entered); end
    run_key(10'h020, 10, nl, nr, first);
    checks++; if (nl !== 1 || digit !== 4'd5) begin errors++;
      $display("FAIL lead_five: got loads=%0d digit=%0d expected 1/5", nl, digit); end
    run_key(10'h001, 10, nl, nr, first);
    checks++; if (nl !== 1 || digit !== 4'd0 || digits_entered !== 2'd2) begin errors++;
      $display("FAIL lead_then_zero: got loads=%0d digit=%0d count=%0d expected 1/0/2", nl, digit, digits_entered); end
  endtask

  task automatic test_bounce();
    int nl, nr, first, tl, tr;
    tl = 0; tr = 0;
    for (int i = 0; i < 10; i++) begin
      keypad = ((i / 2) % 2 == 0) ? 10'h040 : 10'h000;
      @(negedge clk);
      if (load) tl++;
      if (reject) tr++;
    end
    run_key(10'h040, 15, nl, nr, first);
    tl += nl; tr += nr;
    checks++; if (tl !== 1 || tr !== 0) begin errors++;
      $display("FAIL bounce_pulses: got loads=%0d rejects=%0d expected 1/0", tl, tr); end
    checks++; if (digit !== 4'd6 || digits_entered !== 2'd3) begin errors++;
      $display("FAIL bounce_state: got digit=%0d count=%0d expected 6/3", digit, digits_entered); end
  endtask

  task automatic test_chord();
    int nl, nr, first;
    run_key(10'h088, 20, nl, nr, first);
    checks++; if (nl !== 0 || nr !== 0) begin errors++;
      $display("FAIL chord: got loads=%0d rejects=%0d expected 0/0", nl, nr); end
  endtask

  task automatic test_entry_disabled();
    int nl, nr, first;
    entry_en = 1'b0;
    run_key(10'h020, 12, nl, nr, first);
    entry_en = 1'b1;
    checks++; if (nl !== 0 || nr !== 0 || digits_entered !== 2'd3) begin errors++;
      $display("FAIL entry_disabled: got loads=%0d rejects=%0d count=%0d expected 0/0/3", nl, nr, digits_entered); end
  endtask

  task automatic test_clear_entry();
    int nl, nr, first;
    nl = 0; nr = 0;
    keypad = 10'h200;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load) nl++;
      if (reject) nr++;
      clear_entry = (i == 6);
    end
    checks++; if (nl !== 0 || nr !== 0) begin errors++;
      $display("FAIL clr_suppress: got loads=%0d rejects=%0d expected 0/0", nl, nr); end
    checks++; if (digits_entered !== 2'd0) begin errors++;
      $display("FAIL clr_count: got %0d expected 0", digits_entered); end
    run_key(10'h000, 0, nl, nr, first);
    run_key(10'h200, 10, nl, nr, first);
    checks++; if (nl !== 1 || digit !== 4'd9 || digits_entered !== 2'd1) begin errors++;
      $display("FAIL clr_repress: got loads=%0d digit=%0d count=%0d expected 1/9/1", nl, digit, digits_entered); end
  endtask

  task automatic test_async_clear();
    int nl, nr, first;
    pulse_clear_entry();
    run_key(10'h004, 10, nl, nr, first);
    keypad = 10'h010;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2 clear = 1'b1;
    #1;
    checks++; if ({digit, load, reject, digits_entered} !== 8'h00) begin errors++;
      $display("FAIL async_clear: got %h expected 00", {digit, load, reject, digits_entered}); end
    @(negedge clk);
    clear = 1'b0;
    nl = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load) begin nl++; if (first < 0) first = i; end
    end
    checks++; if (nl !== 1 || first !== 7 || digit !== 4'd4) begin errors++;
      $display("FAIL async_repress: got loads=%0d at=%0d digit=%0d expected 1/7/4", nl, first, digit); end
    keypad = '0;
    for (int i = 0; i < 12; i++) @(negedge clk);
  endtask

  initial begin
    clear       = 1'b1;
    keypad      = '0;
    entry_en    = 1'b1;
    clear_entry = 1'b0;
    test_reset();
    test_single_key();
    test_sequence();
    test_tens_limit();
    test_leading_zero();
    test_bounce();
    test_chord();
    test_entry_disabled();
    test_clear_entry();
    test_async_clear();
    checks++; if (both !== 0) begin errors++;
      $display("FAIL load_reject_overlap: got %0d expected 0", both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
- Front-end of the microwave cook-time path, directly upstream of the level-2 countdown (seconds-units / seconds-tens / minutes).
- Turns the raw 10-key numeric keypad into debounced BCD digits, one clean single-cycle load pulse per accepted key press.
- Each pulse shifts the presented digit into the countdown's units position; previous units move to tens, tens to minutes.
- Tracks entry position and rejects presses that would produce an illegal time (tens-of-seconds > 5, more than 3 digits).

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a key state must hold before it is accepted; legal range 1..255.
- MAX_DIGITS, 3, maximum digits accepted per entry (m:ss).

Ports:
- clk  input  1  system clock
- clear  input  1  asynchronous active-high reset
- keypad  input  10  raw key lines, bit k high = key k pressed; asynchronous to clk
- entry_en  input  1  high while the oven is idle and accepting time entry
- clear_entry  input  1  synchronous cancel of the current entry (same cycle the controller clears the countdown)
- digit  output  4  BCD value of the last accepted key; drives the countdown digit input
- load  output  1  one-cycle pulse, digit valid and must be shifted in
- reject  output  1  one-cycle pulse, debounced press refused
- digits_entered  output  2  number of digits accepted in the current entry, 0..MAX_DIGITS

Behaviour:
- Reset (clear high, asynchronous): digit=0, load=0, reject=0, digits_entered=0, units shadow=0, sync flops=0, FSM=IDLE, debounce counter=0.
- Input sync: keypad passes through a 2-flop synchronizer. The encoder acts only on the synchronized value.
- Encoding: exactly one bit high gives code k (0..9), valid=1. Zero or multiple bits high give valid=0 (treated as released).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: valid=1 -> PRESS_DB, counter cleared, candidate code latched.
  - PRESS_DB: count up while valid=1 and code equals candidate. Any change -> IDLE. When count reaches DEBOUNCE_CYCLES -> HELD; the press is evaluated on this transition.
  - HELD: stays while valid=1, including a code change; no second evaluation. valid=0 -> RELEASE_DB.
  - RELEASE_DB: count up while valid=0. valid=1 -> HELD. Count reaches DEBOUNCE_CYCLES -> IDLE.
- Latency: with keypad stable from edge 0, load (or reject) is high for exactly one cycle after edge 2+DEBOUNCE_CYCLES+1.
- Evaluation, first matching rule wins:
  1. entry_en=0: ignored, no pulse.
  2. digits_entered=0 and code=0: ignored (leading zero), no pulse.
  3. digits_entered=MAX_DIGITS: reject.
  4. digits_entered>=1 and units shadow>5: reject, because the shifted value would become tens-of-seconds.
  5. Otherwise: load=1, digit=code, units shadow=code, digits_entered+1.
- digit holds its value between loads. load and reject are never high together.
- clear_entry (synchronous): digits_entered=0, shadow=0, and any load/reject for that cycle is suppressed. The FSM is not reset, so a key held through clear_entry is not re-accepted until released.
- entry_en falling mid-press: debounce continues, and evaluation uses entry_en at evaluation time.
- Asynchronous clear mid-press: everything returns to reset. A still-held key is then seen as a new press after sync and debounce.

Decomposition:
- Shared package: BCD digit type (4 bits), MAX_SECONDS_TENS=5, keypad width constant 10, FSM state enum.
- One natural sub-module: key_debouncer, containing the synchronizer, one-hot encoder, FSM and counter, and emitting a press strobe plus code. The top level holds the entry/validation logic.

Test Plan:
- Reset, then press key 4 held for 20 cycles with DEBOUNCE_CYCLES=4 -> exactly one load, digit=4, at cycle 7 after press. digits_entered=1.
- Keys 1, 3, 0 in sequence -> three loads with digit 1, 3, 0, digits_entered=3. A fourth key 7 -> reject, digit stays 0.
- Key 8 accepted, then key 2 -> reject (shadow 8 > 5). digits_entered stays 1.
- Key 0 with digits_entered=0 -> no load, no reject. Keys 5 then 0 -> loads 5, 0.
- Key 6 bouncing (toggling every 2 cycles for 10 cycles, then stable) -> a single load only. Keys 3 and 7 held together -> no pulse.
- clear_entry asserted in the same cycle as a pending load for key 9 -> no load, digits_entered=0. Asynchronous clear mid-debounce -> all outputs 0 immediately.
